// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART-Lite AXI4-lite access controller.
package uart_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, S_AR, S_R, GAP, D_AR, D_R, AW_W, B, ACK
  } state_t;

  localparam logic [31:0] RX_OFS    = 32'h0000_0000;
  localparam logic [31:0] TX_OFS    = 32'h0000_0004;
  localparam logic [31:0] STAT_OFS  = 32'h0000_0008;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/uart_ctrl_if.sv
// AXI4-lite channel bundle between the UART controller (master) and the peripheral (slave).
interface uart_ctrl_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; grant is one-hot {tx, rx}, pointer flips to the loser on advance.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_req,
  input  logic       tx_req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_rx_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_rx_reg <= 1'b1;
    end else if (advance && (|grant)) begin
      prio_rx_reg <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (prio_rx_reg) begin
      if (rx_req)      grant = 2'b01;
      else if (tx_req) grant = 2'b10;
    end else begin
      if (tx_req)      grant = 2'b10;
      else if (rx_req) grant = 2'b01;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// Schedules putc/getc clients onto the AXI4-lite path to UART-Lite: poll STAT, then move one byte.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          POLL_GAP     = 4,
  parameter int          RX_VALID_BIT = 0,
  parameter int          TX_FULL_BIT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_ack,
  input  logic        rx_req,
  output logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic        err,
  uart_ctrl_if.master axi
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_t      state_reg, state_next;
  logic        gnt_tx_reg, gnt_tx_next;
  logic [7:0]  byte_reg, byte_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic        arvalid_reg, arvalid_next;
  logic        rready_reg, rready_next;
  logic [31:0] araddr_reg, araddr_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        bready_reg, bready_next;
  logic        tx_ack_reg, tx_ack_next;
  logic        rx_ack_reg, rx_ack_next;
  logic        err_reg, err_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        arb_adv;
  logic [1:0]  arb_gnt;
  logic        fifo_ready;
  logic        unused_rdata;

  uart_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_req  (rx_req),
    .tx_req  (tx_req),
    .advance (arb_adv),
    .grant   (arb_gnt)
  );

  assign unused_rdata = ^axi.rdata[31:8];
  assign fifo_ready   = gnt_tx_reg ? !axi.rdata[TX_FULL_BIT] : axi.rdata[RX_VALID_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_tx_reg  <= 1'b0;
      byte_reg    <= 8'h00;
      gap_reg     <= '0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      araddr_reg  <= BASE_ADDR + STAT_OFS;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      wdata_reg   <= 32'h0;
      bready_reg  <= 1'b0;
      tx_ack_reg  <= 1'b0;
      rx_ack_reg  <= 1'b0;
      err_reg     <= 1'b0;
      rx_data_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      gnt_tx_reg  <= gnt_tx_next;
      byte_reg    <= byte_next;
      gap_reg     <= gap_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      araddr_reg  <= araddr_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      wdata_reg   <= wdata_next;
      bready_reg  <= bready_next;
      tx_ack_reg  <= tx_ack_next;
      rx_ack_reg  <= rx_ack_next;
      err_reg     <= err_next;
      rx_data_reg <= rx_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_tx_next  = gnt_tx_reg;
    byte_next    = byte_reg;
    gap_next     = gap_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    araddr_next  = araddr_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    wdata_next   = wdata_reg;
    bready_next  = bready_reg;
    tx_ack_next  = 1'b0;
    rx_ack_next  = 1'b0;
    err_next     = 1'b0;
    rx_data_next = rx_data_reg;
    arb_adv      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|arb_gnt) begin
          arb_adv      = 1'b1;
          gnt_tx_next  = arb_gnt[1];
          byte_next    = tx_data;
          arvalid_next = 1'b1;
          rready_next  = 1'b1;
          araddr_next  = BASE_ADDR + STAT_OFS;
          state_next   = S_AR;
        end
      end
      S_AR: begin
        if (axi.arready) begin
          arvalid_next = 1'b0;
          state_next   = S_R;
        end
      end
      S_R: begin
        if (axi.rvalid && rready_reg) begin
          rready_next = 1'b0;
          if (axi.rresp == RESP_OKAY && fifo_ready) begin
            if (gnt_tx_reg) begin
              awvalid_next = 1'b1;
              wvalid_next  = 1'b1;
              bready_next  = 1'b1;
              wdata_next   = {24'h0, byte_reg};
              state_next   = AW_W;
            end else begin
              arvalid_next = 1'b1;
              rready_next  = 1'b1;
              araddr_next  = BASE_ADDR + RX_OFS;
              state_next   = D_AR;
            end
          end else begin
            gap_next   = GW'(POLL_GAP - 1);
            state_next = GAP;
          end
        end
      end
      // Releasing the grant here lets the other client in while this one's FIFO is not ready.
      GAP: begin
        if (gap_reg == '0) state_next = IDLE;
        else               gap_next   = gap_reg - 1'b1;
      end
      D_AR: begin
        if (axi.arready) begin
          arvalid_next = 1'b0;
          state_next   = D_R;
        end
      end
      D_R: begin
        if (axi.rvalid && rready_reg) begin
          rready_next  = 1'b0;
          rx_data_next = axi.rdata[7:0];
          rx_ack_next  = 1'b1;
          err_next     = (axi.rresp != RESP_OKAY);
          state_next   = ACK;
        end
      end
      AW_W: begin
        if (axi.awready) awvalid_next = 1'b0;
        if (axi.wready)  wvalid_next  = 1'b0;
        if ((!awvalid_reg || axi.awready) && (!wvalid_reg || axi.wready)) state_next = B;
      end
      B: begin
        if (axi.bvalid && bready_reg) begin
          bready_next = 1'b0;
          tx_ack_next = 1'b1;
          err_next    = (axi.bresp != RESP_OKAY);
          state_next  = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign axi.awvalid = awvalid_reg;
  assign axi.awaddr  = BASE_ADDR + TX_OFS;
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = wvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = 4'b0001;
  assign axi.bready  = bready_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = araddr_reg;
  assign axi.arprot  = 3'b000;
  assign axi.rready  = rready_reg;
  assign tx_ack      = tx_ack_reg;
  assign rx_ack      = rx_ack_reg;
  assign err         = err_reg;
  assign rx_data     = rx_data_reg;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a small behavioural UART-Lite AXI4-lite slave.
module tb_uart_ctrl;
  import uart_ctrl_pkg::*;

  localparam logic [31:0] A_RX   = 32'h4000_0000;
  localparam logic [31:0] A_TX   = 32'h4000_0004;
  localparam logic [31:0] A_STAT = 32'h4000_0008;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_req = 1'b0;
  logic       tx_ack, rx_ack, err;
  logic [7:0] rx_data;

  uart_ctrl_if axi ();

  uart_ctrl #(
    .BASE_ADDR(32'h4000_0000), .POLL_GAP(4), .RX_VALID_BIT(0), .TX_FULL_BIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack), .err(err), .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave configuration and logs
  logic [31:0] stat_ready_val = 32'h0, stat_busy_val = 32'h8;
  int          busy_left = 0;
  logic [7:0]  rx_byte = 8'h00;
  logic [1:0]  bresp_cfg = 2'b00;
  int          aw_stall = 0, w_stall = 0;
  logic [31:0] ar_log[$];
  int          poll_cyc[$];
  int          aw_cnt = 0, w_cnt = 0, aw_hi = 0, w_hi = 0, proto_viol = 0;
  logic [31:0] aw_addr_log = 0, wdata_log = 0;
  logic [3:0]  wstrb_log = 0;
  bit          ar_fire = 0, aw_got = 0, w_got = 0, r_done = 0, b_done = 0;
  logic [31:0] ar_addr_q = 0;
  bit          aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [31:0] aw_prev = 0, w_prev = 0, ar_prev = 0;
  int          tx_ack_cnt = 0, rx_ack_cnt = 0;
  bit          tx_open = 0, rx_open = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : slave
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.rvalid = 0; axi.bvalid = 0; axi.awready = 0; axi.wready = 0; axi.arready = 0;
        ar_fire = 0; aw_got = 0; w_got = 0; r_done = 0; b_done = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
      end else begin
        if (aw_pend && (!axi.awvalid || axi.awaddr != aw_prev)) proto_viol++;
        if (w_pend && (!axi.wvalid || axi.wdata != w_prev)) proto_viol++;
        if (ar_pend && (!axi.arvalid || axi.araddr != ar_prev)) proto_viol++;
        if (r_done) begin axi.rvalid = 0; r_done = 0; end
        if (b_done) begin axi.bvalid = 0; b_done = 0; end
        if (ar_fire) begin
          ar_fire = 0;
          axi.rvalid = 1;
          axi.rresp = 2'b00;
          if (ar_addr_q == A_STAT) begin
            if (busy_left > 0) begin axi.rdata = stat_busy_val; busy_left--; end
            else axi.rdata = stat_ready_val;
          end else begin
            axi.rdata = {24'h0, rx_byte};
          end
        end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; axi.bvalid = 1; axi.bresp = bresp_cfg;
        end
        axi.arready = 1;
        if (axi.awvalid && aw_stall > 0) begin axi.awready = 0; aw_stall--; end
        else axi.awready = 1;
        if (axi.wvalid && w_stall > 0) begin axi.wready = 0; w_stall--; end
        else axi.wready = 1;
        if (axi.awvalid) aw_hi++;
        if (axi.wvalid) w_hi++;
        if (axi.arvalid && axi.arready) begin
          ar_fire = 1; ar_addr_q = axi.araddr; ar_log.push_back(axi.araddr);
          if (axi.araddr == A_STAT) poll_cyc.push_back(cyc);
        end
        if (axi.rvalid && axi.rready) r_done = 1;
        if (axi.awvalid && axi.awready) begin aw_got = 1; aw_cnt++; aw_addr_log = axi.awaddr; end
        if (axi.wvalid && axi.wready) begin
          w_got = 1; w_cnt++; wdata_log = axi.wdata; wstrb_log = axi.wstrb;
        end
        if (axi.bvalid && axi.bready) b_done = 1;
        aw_pend = axi.awvalid && !axi.awready; aw_prev = axi.awaddr;
        w_pend  = axi.wvalid && !axi.wready;   w_prev  = axi.wdata;
        ar_pend = axi.arvalid && !axi.arready; ar_prev = axi.araddr;
      end
    end
  end

  // Ack counting and client-protocol monitor (req must stay high until its ack).
  initial forever begin
    @(negedge clk);
    #1;
    if (tx_ack) tx_ack_cnt++;
    if (rx_ack) rx_ack_cnt++;
    if (!rst_n) begin
      tx_open = 0; rx_open = 0;
    end else begin
      if (tx_open && !tx_req && !tx_ack) begin
        errors++; $display("FAIL req_drop_tx: tx_req=0 before tx_ack, need 1");
      end
      if (rx_open && !rx_req && !rx_ack) begin
        errors++; $display("FAIL req_drop_rx: rx_req=0 before rx_ack, need 1");
      end
      tx_open = tx_req && !tx_ack;
      rx_open = rx_req && !rx_ack;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; tx_req = 0; rx_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(input bit is_tx, input int budget, output int cycles, output logic err_seen);
    cycles = -1;
    err_seen = 1'bx;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if ((is_tx && tx_ack) || (!is_tx && rx_ack)) begin
        cycles = n; err_seen = err; return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_valids: got %b need 00000",
                         {axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready});
    end
    checks++;
    if ({tx_ack, rx_ack, err} !== 3'b000) begin
      errors++; $display("FAIL reset_acks: got %b need 000", {tx_ack, rx_ack, err});
    end
    checks++;
    if (axi.araddr !== A_STAT || axi.wdata !== 32'h0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_regs: araddr=%h wdata=%h rx_data=%h need %h 0 0",
                         axi.araddr, axi.wdata, rx_data, A_STAT);
    end
    checks++;
    if (axi.awaddr !== A_TX || axi.wstrb !== 4'b0001 || axi.awprot !== 3'b0 || axi.arprot !== 3'b0) begin
      errors++; $display("FAIL const_outs: awaddr=%h wstrb=%b awprot=%b arprot=%b",
                         axi.awaddr, axi.wstrb, axi.awprot, axi.arprot);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_tx_basic();
    int lat; logic e;
    stat_ready_val = 32'h0; busy_left = 0; bresp_cfg = 2'b00;
    aw_cnt = 0; w_cnt = 0;
    @(negedge clk);
    tx_data = 8'h41; tx_req = 1;
    wait_ack(1, 30, lat, e);
    tx_req = 0;
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL tx_latency: got %0d need 5", lat); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL tx_err: got %b need 0", e); end
    checks++;
    if (aw_addr_log !== A_TX || wdata_log !== 32'h41 || wstrb_log !== 4'b0001) begin
      errors++; $display("FAIL tx_write: awaddr=%h wdata=%h wstrb=%b need %h 41 0001",
                         aw_addr_log, wdata_log, wstrb_log, A_TX);
    end
    checks++;
    if (aw_cnt !== 1 || w_cnt !== 1) begin
      errors++; $display("FAIL tx_write_count: aw=%0d w=%0d need 1 1", aw_cnt, w_cnt);
    end
    repeat (3) @(negedge clk);
    $display("test_tx_basic latency=%0d", lat);
  endtask

  task automatic test_rx_basic();
    int lat; logic e; logic [31:0] a0, a1;
    stat_ready_val = 32'h1; busy_left = 0; rx_byte = 8'h5A;
    ar_log.delete();
    @(negedge clk);
    rx_req = 1;
    wait_ack(0, 30, lat, e);
    rx_req = 0;
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL rx_latency: got %0d need 5", lat); end
    checks++;
    if (rx_data !== 8'h5A || e !== 1'b0) begin
      errors++; $display("FAIL rx_data: got %h err=%b need 5a err=0", rx_data, e);
    end
    a0 = (ar_log.size() > 0) ? ar_log[0] : 32'hx;
    a1 = (ar_log.size() > 1) ? ar_log[1] : 32'hx;
    checks++;
    if (ar_log.size() != 2 || a0 !== A_STAT || a1 !== A_RX) begin
      errors++; $display("FAIL rx_ar_seq: n=%0d a0=%h a1=%h need 2 %h %h",
                         ar_log.size(), a0, a1, A_STAT, A_RX);
    end
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h5A || rx_ack !== 1'b0) begin
      errors++; $display("FAIL rx_hold: rx_data=%h rx_ack=%b need 5a 0", rx_data, rx_ack);
    end
    repeat (3) @(negedge clk);
    $display("test_rx_basic latency=%0d data=%h", lat, rx_data);
  endtask

  task automatic test_tx_poll();
    int lat; logic e; int acks0;
    stat_ready_val = 32'h0; stat_busy_val = 32'h8; busy_left = 3;
    aw_cnt = 0; w_cnt = 0; poll_cyc.delete();
    acks0 = tx_ack_cnt;
    @(negedge clk);
    tx_data = 8'h7E; tx_req = 1;
    wait_ack(1, 100, lat, e);
    tx_req = 0;
    checks++;
    if (lat !== 26) begin errors++; $display("FAIL poll_latency: got %0d need 26", lat); end
    checks++;
    if (poll_cyc.size() != 4) begin
      errors++; $display("FAIL poll_count: got %0d need 4", poll_cyc.size());
    end
    for (int i = 1; i < poll_cyc.size(); i++) begin
      checks++;
      if (poll_cyc[i] - poll_cyc[i-1] != 7) begin
        errors++; $display("FAIL poll_spacing%0d: got %0d need 7", i, poll_cyc[i] - poll_cyc[i-1]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (aw_cnt !== 1 || w_cnt !== 1 || tx_ack_cnt - acks0 != 1 || wdata_log !== 32'h7E) begin
      errors++; $display("FAIL poll_single_write: aw=%0d w=%0d acks=%0d wdata=%h need 1 1 1 7e",
                         aw_cnt, w_cnt, tx_ack_cnt - acks0, wdata_log);
    end
    $display("test_tx_poll latency=%0d polls=%0d", lat, poll_cyc.size());
  endtask

  task automatic test_both();
    int rx_at, tx_at, rx0, tx0;
    do_reset();
    stat_ready_val = 32'h1; busy_left = 0; rx_byte = 8'h33;
    rx_at = -1; tx_at = -1;
    rx0 = rx_ack_cnt; tx0 = tx_ack_cnt;
    @(negedge clk);
    tx_data = 8'h55; tx_req = 1; rx_req = 1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (rx_ack && rx_at < 0) begin rx_at = n; rx_req = 0; end
      if (tx_ack && tx_at < 0) begin tx_at = n; tx_req = 0; end
      if (rx_at >= 0 && tx_at >= 0) break;
    end
    tx_req = 0; rx_req = 0;
    checks++;
    if (rx_at !== 5) begin errors++; $display("FAIL both_rx_first: rx_ack at %0d need 5", rx_at); end
    checks++;
    if (tx_at !== 11) begin errors++; $display("FAIL both_tx_second: tx_ack at %0d need 11", tx_at); end
    repeat (6) @(negedge clk);
    checks++;
    if (rx_ack_cnt - rx0 != 1 || tx_ack_cnt - tx0 != 1) begin
      errors++; $display("FAIL both_ack_once: rx=%0d tx=%0d need 1 1", rx_ack_cnt - rx0, tx_ack_cnt - tx0);
    end
    $display("test_both rx_at=%0d tx_at=%0d", rx_at, tx_at);
  endtask

  task automatic test_stall_err();
    int lat; logic e;
    stat_ready_val = 32'h0; busy_left = 0; bresp_cfg = 2'b10;
    aw_hi = 0; w_hi = 0; proto_viol = 0;
    @(negedge clk);
    aw_stall = 3; w_stall = 1;
    tx_data = 8'hC3; tx_req = 1;
    wait_ack(1, 40, lat, e);
    tx_req = 0;
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL stall_latency: got %0d need 8", lat); end
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL stall_err: got %b need 1", e); end
    checks++;
    if (aw_hi !== 4 || w_hi !== 2) begin
      errors++; $display("FAIL stall_valid_hold: awvalid cycles=%0d wvalid cycles=%0d need 4 2", aw_hi, w_hi);
    end
    checks++;
    if (proto_viol !== 0 || wdata_log !== 32'hC3) begin
      errors++; $display("FAIL stall_protocol: violations=%0d wdata=%h need 0 c3", proto_viol, wdata_log);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b need 0", err); end
    bresp_cfg = 2'b00;
    repeat (3) @(negedge clk);
    $display("test_stall_err latency=%0d err=%b", lat, e);
  endtask

  task automatic test_reset_mid();
    int lat; logic e; int rx0;
    stat_ready_val = 32'h1; busy_left = 0; rx_byte = 8'h77;
    rx0 = rx_ack_cnt;
    @(negedge clk);
    rx_req = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== A_RX) begin
      errors++; $display("FAIL mid_d_ar: arvalid=%b araddr=%h need 1 %h", axi.arvalid, axi.araddr, A_RX);
    end
    rst_n = 0; rx_req = 0;
    @(negedge clk);
    checks++;
    if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset_drop: arvalid=%b rready=%b rx_data=%h need 0 0 00",
                         axi.arvalid, axi.rready, rx_data);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_ack_cnt - rx0 != 0) begin
      errors++; $display("FAIL mid_no_ack: rx_ack count %0d need 0", rx_ack_cnt - rx0);
    end
    rx_req = 1;
    wait_ack(0, 30, lat, e);
    rx_req = 0;
    checks++;
    if (lat !== 5 || rx_data !== 8'h77) begin
      errors++; $display("FAIL mid_rerequest: latency=%0d data=%h need 5 77", lat, rx_data);
    end
    repeat (3) @(negedge clk);
    $display("test_reset_mid relatency=%0d data=%h", lat, rx_data);
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_basic();
    test_tx_poll();
    test_both();
    test_stall_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, need finish");
    $fatal(1, "timeout");
  end

endmodule
